cc_sched: RTL and testbench

- Round-robin scheduler that shares one combinational code-calculator datapath (four 4-bit operands, 4-bit opt, 9-bit out_n) between NUM_REQ requesters.
- Arbitrates, registers the datapath inputs, waits a programmable settle time, captures out_n and returns it tagged with the requester id over a valid/ready response channel.
- Sits between requester front-ends and the single calculator instance.

---
 rtl/cc_pkg.sv | 25 ++
 rtl/cc_sched_if.sv | 42 ++++
 rtl/cc_rr_arbiter.sv | 44 ++++
 rtl/cc_sched.sv | 148 ++++++++++++++
 tb/tb_cc_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_pkg
// Description : Shared widths and FSM state encoding for the code-calculator
//               scheduler (cc_sched) and its interface.
// Contents    : NIB_W      - operand nibble width
//               OPT_W      - opt field width
//               OUT_W      - calculator result width
//               REQ_PACK_W - packed operand width per requester {n3,n2,n1,n0}
//               IDLE/DRIVE/RESP - scheduler state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package cc_pkg;

    localparam int NIB_W      = 4;
    localparam int OPT_W      = 4;
    localparam int OUT_W      = 9;
    localparam int REQ_PACK_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

endpackage : cc_pkg
`default_nettype wire

// File: rtl/cc_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : cc_sched_if
// Description : Request/response bundle between the requester front-ends /
//               result consumer (master) and the scheduler (slave).
// Signals     : req_valid [NUM_REQ]          per-requester request
//               req_ready [NUM_REQ]          per-requester accept (one-hot/0)
//               req_data  [NUM_REQ*16]       {n3,n2,n1,n0} per requester
//               req_opt   [NUM_REQ*4]        opt per requester
//               rsp_valid / rsp_ready        result handshake
//               rsp_id    [ID_W]             owner of the result
//               rsp_data  [9]                captured calculator output
// Revision    : 1.0 - initial release
// ============================================================================
interface cc_sched_if
    import cc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*REQ_PACK_W-1:0] req_data;
    logic [NUM_REQ*OPT_W-1:0]      req_opt;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [OUT_W-1:0]              rsp_data;

    modport master (
        output req_valid, req_data, req_opt, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_opt, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface : cc_sched_if
`default_nettype wire

// File: rtl/cc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cc_rr_arbiter
// Description : Combinational round-robin pick. Searches req starting at
//               rr_ptr and wrapping modulo NUM_REQ; first set bit wins.
// Ports       : req       in  NUM_REQ  request vector
//               rr_ptr    in  ID_W     highest-priority index
//               grant     out NUM_REQ  one-hot grant (0 if no request)
//               grant_idx out ID_W     index of the granted requester
//               any_grant out 1        at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module cc_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [ID_W-1:0]    rr_ptr,
    output logic      [NUM_REQ-1:0] grant,
    output logic      [ID_W-1:0]    grant_idx,
    output logic                    any_grant
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_idx     = '0;
        // Walk priority order rr_ptr, rr_ptr+1, ...; the first hit locks out
        // all later candidates via any_grant.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_grant && req[w_idx]) begin
                any_grant    = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule : cc_rr_arbiter
`default_nettype wire

// File: rtl/cc_sched.sv
`default_nettype none
// ============================================================================
// Module      : cc_sched
// Description : Round-robin scheduler sharing one combinational code
//               calculator between NUM_REQ requesters. Grants one request,
//               registers the operands onto cc_*, waits SETTLE_CYC cycles,
//               captures cc_out_n and returns it tagged with the owner id.
// Ports       : clk       in   clock (rising edge)
//               rst_n     in   asynchronous active-low reset
//               bus       slave modport of cc_sched_if (req/rsp channels)
//               cc_in_n0..cc_in_n3 out 4   registered calculator operands
//               cc_opt    out  4           registered calculator opt
//               cc_out_n  in   9           calculator result
//               busy      out  1           high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module cc_sched
    import cc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int SETTLE_CYC = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    cc_sched_if.slave             bus,
    output logic      [NIB_W-1:0] cc_in_n0,
    output logic      [NIB_W-1:0] cc_in_n1,
    output logic      [NIB_W-1:0] cc_in_n2,
    output logic      [NIB_W-1:0] cc_in_n3,
    output logic      [OPT_W-1:0] cc_opt,
    input  wire logic [OUT_W-1:0] cc_out_n,
    output logic                  busy
);

    localparam int           CNT_W      = 4;
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]            r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [NIB_W-1:0]      r_cc_n0;
    logic [NIB_W-1:0]      r_cc_n1;
    logic [NIB_W-1:0]      r_cc_n2;
    logic [NIB_W-1:0]      r_cc_n3;
    logic [OPT_W-1:0]      r_cc_opt;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [OUT_W-1:0]      r_rsp_data;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_idx;
    logic                  w_any_grant;
    logic [REQ_PACK_W-1:0] w_sel_data;
    logic [OPT_W-1:0]      w_sel_opt;
    logic [ID_W-1:0]       w_ptr_next;

    cc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (bus.req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_grant (w_any_grant)
    );

    // One-hot mux of the granted requester's operand slice.
    always_comb begin
        w_sel_data = '0;
        w_sel_opt  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_grant[r]) begin
                w_sel_data = bus.req_data[r*REQ_PACK_W +: REQ_PACK_W];
                w_sel_opt  = bus.req_opt[r*OPT_W +: OPT_W];
            end
        end
    end

    // Priority moves to the requester after the one just served.
    assign w_ptr_next = (r_rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : r_rsp_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_cc_n0     <= '0;
            r_cc_n1     <= '0;
            r_cc_n2     <= '0;
            r_cc_n3     <= '0;
            r_cc_opt    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // req_ready mirrors the grant here, so any grant is a handshake.
                    if (w_any_grant) begin
                        r_cc_n0  <= w_sel_data[0*NIB_W +: NIB_W];
                        r_cc_n1  <= w_sel_data[1*NIB_W +: NIB_W];
                        r_cc_n2  <= w_sel_data[2*NIB_W +: NIB_W];
                        r_cc_n3  <= w_sel_data[3*NIB_W +: NIB_W];
                        r_cc_opt <= w_sel_opt;
                        r_rsp_id <= w_grant_idx;
                        r_cnt    <= c_CNT_INIT;
                        r_state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= cc_out_n;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_ptr_next;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;

    assign cc_in_n0 = r_cc_n0;
    assign cc_in_n1 = r_cc_n1;
    assign cc_in_n2 = r_cc_n2;
    assign cc_in_n3 = r_cc_n3;
    assign cc_opt   = r_cc_opt;
    assign busy     = (r_state != IDLE);

endmodule : cc_sched
`default_nettype wire

// File: tb/tb_cc_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cc_sched
// Description : Testbench for cc_sched. Two instances: SETTLE_CYC=1 (main)
//               and SETTLE_CYC=4. Calculator stub returns n0+n1+n2+n3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_sched;
    import cc_pkg::*;

    logic clk = 1'b0;
    logic rst1_n;
    logic rst4_n;
    always #5 clk = ~clk;

    cc_sched_if #(.NUM_REQ(4), .ID_W(2)) bus1 ();
    cc_sched_if #(.NUM_REQ(4), .ID_W(2)) bus4 ();

    logic [3:0] n0_1, n1_1, n2_1, n3_1, opt_1;
    logic [3:0] n0_4, n1_4, n2_4, n3_4, opt_4;
    logic [8:0] out_1, out_4;
    logic       busy_1, busy_4;

    assign out_1 = 9'(n0_1) + 9'(n1_1) + 9'(n2_1) + 9'(n3_1);
    assign out_4 = 9'(n0_4) + 9'(n1_4) + 9'(n2_4) + 9'(n3_4);

    cc_sched #(.NUM_REQ(4), .ID_W(2), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(bus1),
        .cc_in_n0(n0_1), .cc_in_n1(n1_1), .cc_in_n2(n2_1), .cc_in_n3(n3_1),
        .cc_opt(opt_1), .cc_out_n(out_1), .busy(busy_1)
    );

    cc_sched #(.NUM_REQ(4), .ID_W(2), .SETTLE_CYC(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(bus4),
        .cc_in_n0(n0_4), .cc_in_n1(n1_4), .cc_in_n2(n2_4), .cc_in_n3(n3_4),
        .cc_opt(opt_4), .cc_out_n(out_4), .busy(busy_4)
    );

    int checks;
    int errors;
    int exp_ptr;                 // model of the round-robin pointer
    logic [15:0] dat [4];        // per-requester operands {n3,n2,n1,n0}
    logic [3:0]  opv [4];        // per-requester opt

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: first valid requester in circular order from ptr.
    function automatic int rr_pick(input logic [3:0] v, input int ptr);
        logic [1:0] idx;
        for (int k = 0; k < 4; k++) begin
            idx = 2'((ptr + k) % 4);
            if (v[idx]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [8:0] ref_sum(input logic [15:0] d);
        return 9'(d[3:0]) + 9'(d[7:4]) + 9'(d[11:8]) + 9'(d[15:12]);
    endfunction

    task automatic drive_data1();
        bus1.req_data = {dat[3], dat[2], dat[1], dat[0]};
        bus1.req_opt  = {opv[3], opv[2], opv[1], opv[0]};
    endtask

    task automatic rand_data();
        for (int r = 0; r < 4; r++) begin
            dat[r] = 16'($urandom);
            opv[r] = 4'($urandom);
        end
    endtask

    task automatic chk_zero1(input string tag);
        check({tag, ".cc"},  32'({n3_1, n2_1, n1_1, n0_1, opt_1}), 32'(0));
        check({tag, ".rsp"}, 32'({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data}), 32'(0));
        check({tag, ".rdy_busy"}, 32'({bus1.req_ready, busy_1}), 32'(0));
    endtask

    // One full transaction on dut1 from an IDLE cycle; stall = RESP cycles with rsp_ready low.
    task automatic txn1(input string tag, input logic [3:0] valid, input int stall);
        int g;
        int lat;
        logic [15:0] d;
        logic [8:0]  es;
        drive_data1();
        bus1.req_valid = valid;
        bus1.rsp_ready = (stall == 0);
        #1;
        g  = rr_pick(valid, exp_ptr);
        d  = dat[g];
        es = ref_sum(d);
        check({tag, ".grant"}, 32'(bus1.req_ready), 32'(1) << g);
        @(posedge clk); #1;
        check({tag, ".cc_in"}, 32'({n3_1, n2_1, n1_1, n0_1, opt_1}), 32'({d, opv[g]}));
        check({tag, ".drive_rdy_busy"}, 32'({bus1.req_ready, busy_1}), 32'({4'b0000, 1'b1}));
        lat = 0;
        while (bus1.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(1));
        check({tag, ".rsp"}, 32'({bus1.rsp_id, bus1.rsp_data}), 32'({2'(g), es}));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, ".stall"}, 32'({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data, bus1.req_ready, busy_1}),
                  32'({1'b1, 2'(g), es, 4'b0000, 1'b1}));
        end
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".done"}, 32'({bus1.rsp_valid, busy_1}), 32'(0));
        exp_ptr = (g + 1) % 4;
    endtask

    initial begin : stim
        int lat;
        logic [15:0] d4;
        logic [3:0]  o4;
        logic [19:0] snap;
        logic [3:0]  v;

        checks  = 0;
        errors  = 0;
        exp_ptr = 0;
        rst1_n  = 1'b0;
        rst4_n  = 1'b0;
        bus1.req_valid = '0; bus1.req_data = '0; bus1.req_opt = '0; bus1.rsp_ready = 1'b0;
        bus4.req_valid = '0; bus4.req_data = '0; bus4.req_opt = '0; bus4.rsp_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            dat[r] = '0;
            opv[r] = '0;
        end

        // Reset state
        #12;
        chk_zero1("reset1");
        check("reset4", 32'({n3_4, n2_4, n1_4, n0_4, opt_4, bus4.rsp_valid, busy_4}), 32'(0));
        @(posedge clk); #1;
        rst1_n = 1'b1;
        rst4_n = 1'b1;

        // No request: stay idle
        repeat (3) @(posedge clk);
        #1;
        check("idle", 32'({bus1.req_ready, busy_1, bus1.rsp_valid}), 32'(0));

        // 1. Single request, sum 0+1+2+3
        dat[0] = 16'h3210;
        opv[0] = 4'h5;
        txn1("t1", 4'b0001, 0);
        check("t1.sum", 32'(bus1.rsp_data), 32'(6));

        // 2. Round-robin with all four held
        rand_data();
        for (int i = 0; i < 5; i++) txn1("t2", 4'b1111, 0);

        // 3. Backpressure with maximal operands, then next grant
        for (int r = 0; r < 4; r++) dat[r] = 16'hFFFF;
        txn1("t3", 4'b1111, 10);
        check("t3.sum", 32'(bus1.rsp_data), 32'(60));
        rand_data();
        txn1("t3.next", 4'b1111, 0);

        // 4. Wrap and skip: serve 2 then 0101 grants 0 then 2
        rand_data();
        txn1("t4.a", 4'b0100, 0);
        txn1("t4.b", 4'b0101, 0);
        txn1("t4.c", 4'b0101, 0);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            rand_data();
            v = 4'($urandom_range(1, 15));
            txn1("rnd", v, int'($urandom_range(0, 3)));
        end

        // 5. SETTLE_CYC=4 instance
        d4 = 16'($urandom);
        o4 = 4'($urandom);
        bus4.req_data  = {16'h0, 16'h0, d4, 16'h0};
        bus4.req_opt   = {4'h0, 4'h0, o4, 4'h0};
        bus4.req_valid = 4'b0010;
        bus4.rsp_ready = 1'b1;
        #1;
        check("t5.grant", 32'(bus4.req_ready), 32'(4'b0010));
        @(posedge clk); #1;
        bus4.req_valid = 4'b0000;
        snap = {n3_4, n2_4, n1_4, n0_4, opt_4};
        check("t5.cc_in", 32'(snap), 32'({d4, o4}));
        lat = 0;
        while (bus4.rsp_valid !== 1'b1 && lat < 40) begin
            check("t5.cc_hold", 32'({n3_4, n2_4, n1_4, n0_4, opt_4, busy_4}), 32'({snap, 1'b1}));
            @(posedge clk); #1;
            lat++;
        end
        check("t5.latency", 32'(lat), 32'(4));
        check("t5.rsp", 32'({bus4.rsp_id, bus4.rsp_data}), 32'({2'd1, ref_sum(d4)}));
        @(posedge clk); #1;
        check("t5.done", 32'({bus4.rsp_valid, busy_4}), 32'(0));

        // 6a. Reset while in DRIVE
        rand_data();
        drive_data1();
        bus1.req_valid = 4'b0010;
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t6a.busy", 32'(busy_1), 32'(1));
        rst1_n = 1'b0;
        bus1.req_valid = 4'b0000;
        #2;
        chk_zero1("t6a.rst");
        @(posedge clk); #1;
        rst1_n = 1'b1;
        exp_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("t6a.no_rsp", 32'({bus1.rsp_valid, busy_1}), 32'(0));
        txn1("t6a.ptr0", 4'b1001, 0);

        // 6b. Reset while in RESP
        exp_ptr = 1;
        rand_data();
        drive_data1();
        bus1.req_valid = 4'b0010;
        bus1.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus1.req_valid = 4'b0000;
        lat = 0;
        while (bus1.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t6b.resp", 32'({bus1.rsp_valid, bus1.rsp_id}), 32'({1'b1, 2'd1}));
        #2;
        rst1_n = 1'b0;
        #1;
        chk_zero1("t6b.rst");
        @(posedge clk); #1;
        rst1_n = 1'b1;
        exp_ptr = 0;
        txn1("t6b.wrap", 4'b1000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cc_sched
`default_nettype wire
